// File: rtl/esti_axis_integrator.sv
// Multi-axis bias-calibrated double integrator: captures big-endian samples from the
// I2C frame, learns per-axis bias, integrates to saturating vel/pos, drives LED band code.

module esti_axis_lane #(
  parameter int SAMPLE_W = 16,
  parameter int VEL_W    = 32,
  parameter int POS_W    = 64,
  parameter int CAL_LOG2 = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr,
  input  logic                       cap,
  input  logic [15:0]                word,
  input  logic                       cal_en,
  input  logic                       cal_last,
  input  logic                       int_en,
  input  logic                       pos_en,
  output logic signed [VEL_W-1:0]    vel,
  output logic signed [POS_W-1:0]    pos,
  output logic                       sat
);
  localparam int SW = SAMPLE_W + CAL_LOG2;
  localparam int DW = SAMPLE_W + 1;
  // Adds run one bit wider than the widest operand so the clamp sees the true sum.
  localparam int AW = ((VEL_W > DW) ? VEL_W : DW) + 1;
  localparam int PW = ((POS_W > VEL_W) ? POS_W : VEL_W) + 1;
  localparam logic signed [AW-1:0] VMAX = {{(AW-VEL_W+1){1'b0}}, {(VEL_W-1){1'b1}}};
  localparam logic signed [AW-1:0] VMIN = {{(AW-VEL_W+1){1'b1}}, {(VEL_W-1){1'b0}}};
  localparam logic signed [PW-1:0] PMAX = {{(PW-POS_W+1){1'b0}}, {(POS_W-1){1'b1}}};
  localparam logic signed [PW-1:0] PMIN = {{(PW-POS_W+1){1'b1}}, {(POS_W-1){1'b0}}};

  logic signed [SAMPLE_W-1:0] samp, bias;
  logic signed [SW-1:0]       sum, sum_nxt;
  logic signed [DW-1:0]       acc;
  logic signed [AW-1:0]       vwide;
  logic signed [PW-1:0]       pwide;
  logic signed [VEL_W-1:0]    vel_nxt;
  logic signed [POS_W-1:0]    pos_nxt;
  logic                       vclamp, pclamp;

  always_comb begin
    sum_nxt = sum + SW'(samp);
    acc     = DW'(samp) - DW'(bias);
    vwide   = AW'(vel) + AW'(acc);
    pwide   = PW'(pos) + PW'(vel);
  end

  always_comb begin
    vclamp  = 1'b0;
    vel_nxt = vwide[VEL_W-1:0];
    if (vwide > VMAX) begin
      vel_nxt = {1'b0, {(VEL_W-1){1'b1}}};
      vclamp  = 1'b1;
    end else if (vwide < VMIN) begin
      vel_nxt = {1'b1, {(VEL_W-1){1'b0}}};
      vclamp  = 1'b1;
    end
  end

  always_comb begin
    pclamp  = 1'b0;
    pos_nxt = pwide[POS_W-1:0];
    if (pwide > PMAX) begin
      pos_nxt = {1'b0, {(POS_W-1){1'b1}}};
      pclamp  = 1'b1;
    end else if (pwide < PMIN) begin
      pos_nxt = {1'b1, {(POS_W-1){1'b0}}};
      pclamp  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      samp <= '0;
      sum  <= '0;
      bias <= '0;
      vel  <= '0;
      pos  <= '0;
      sat  <= 1'b0;
    end else if (clr) begin
      sum  <= '0;
      vel  <= '0;
      pos  <= '0;
      sat  <= 1'b0;
    end else begin
      if (cap) samp <= word[SAMPLE_W-1:0];
      if (cal_en) begin
        if (cal_last) begin
          sum  <= '0;
          bias <= SAMPLE_W'(sum_nxt >>> CAL_LOG2);
          vel  <= '0;
          pos  <= '0;
        end else begin
          sum  <= sum_nxt;
        end
      end
      if (int_en) begin
        vel <= vel_nxt;
        if (vclamp) sat <= 1'b1;
      end
      // pos accumulates the already-updated velocity from the previous stage
      if (pos_en) begin
        pos <= pos_nxt;
        if (pclamp) sat <= 1'b1;
      end
    end
  end
endmodule

module esti_axis_integrator #(
  parameter int          NUM_AXES  = 3,
  parameter int          SAMPLE_W  = 16,
  parameter int          VEL_W     = 32,
  parameter int          POS_W     = 64,
  parameter int          CAL_LOG2  = 4,
  parameter logic [63:0] BAND_STEP = 64'h0000_0000_c26d_d3e6,
  parameter int          NUM_BANDS = 5,
  parameter int          LED_AXIS  = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        frame_done,
  input  logic [16*NUM_AXES-1:0]      rx_bytes,
  input  logic                        recal,
  output logic [VEL_W*NUM_AXES-1:0]   vel,
  output logic [POS_W*NUM_AXES-1:0]   pos,
  output logic [7:0]                  led_out,
  output logic                        cal_done,
  output logic                        upd_valid,
  output logic [NUM_AXES-1:0]         sat,
  output logic                        overrun
);
  localparam int STAGES = 3;
  localparam int TW = ((POS_W > 64) ? POS_W : 64) + 9;

  typedef enum logic {CAL, RUN} state_t;
  state_t state, state_nxt;

  logic                             frame_done_q, frame_edge, busy, accept;
  logic [STAGES:0]                  vld_pipe, run_pipe;
  logic [CAL_LOG2-1:0]              cal_cnt;
  logic                             cal_en, cal_fin, int_en, pos_en;
  logic [NUM_AXES-1:0][15:0]        word_a;
  logic [NUM_AXES-1:0][VEL_W-1:0]   vel_a;
  logic [NUM_AXES-1:0][POS_W-1:0]   pos_a;
  logic [POS_W-1:0]                 p_u;
  logic [TW-1:0]                    p_ext;
  logic [7:0]                       band;

  assign frame_edge = frame_done & ~frame_done_q;
  // A frame occupies the pipe for the three cycles after its edge.
  assign busy       = |vld_pipe[STAGES-1:0];
  assign accept     = frame_edge & ~busy & ~recal;
  assign cal_en     = vld_pipe[0] & ~run_pipe[0];
  assign int_en     = vld_pipe[0] &  run_pipe[0];
  assign pos_en     = vld_pipe[1] &  run_pipe[1];
  assign cal_fin    = cal_en & (cal_cnt == {CAL_LOG2{1'b1}});
  assign upd_valid  = vld_pipe[STAGES] & run_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (reset) state <= CAL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (recal)                         state_nxt = CAL;
    else if (state == CAL && cal_fin)  state_nxt = RUN;
  end

  always_comb begin
    cal_done = (state == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_done_q <= 1'b0;
      vld_pipe     <= '0;
      run_pipe     <= '0;
      overrun      <= 1'b0;
      cal_cnt      <= '0;
    end else begin
      frame_done_q <= frame_done;
      if (recal) begin
        vld_pipe <= '0;
        run_pipe <= '0;
        overrun  <= 1'b0;
        cal_cnt  <= '0;
      end else begin
        vld_pipe <= {vld_pipe[STAGES-1:0], accept};
        run_pipe <= {run_pipe[STAGES-1:0], state == RUN};
        if (frame_edge & busy) overrun <= 1'b1;
        if (cal_en) cal_cnt <= cal_cnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_AXES; i++) begin : g_lane
    assign word_a[i] = {rx_bytes[16*i +: 8], rx_bytes[16*i+8 +: 8]};
    esti_axis_lane #(
      .SAMPLE_W (SAMPLE_W),
      .VEL_W    (VEL_W),
      .POS_W    (POS_W),
      .CAL_LOG2 (CAL_LOG2)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .clr      (recal),
      .cap      (accept),
      .word     (word_a[i]),
      .cal_en   (cal_en),
      .cal_last (cal_fin),
      .int_en   (int_en),
      .pos_en   (pos_en),
      .vel      (vel_a[i]),
      .pos      (pos_a[i]),
      .sat      (sat[i])
    );
  end

  assign vel = vel_a;
  assign pos = pos_a;

  // Comparator chain against k*BAND_STEP; the highest threshold met picks the band.
  always_comb begin
    p_u   = pos_a[LED_AXIS];
    p_ext = TW'(p_u);
    band  = 8'h01;
    for (int k = 1; k < NUM_BANDS; k++)
      if (p_ext >= TW'(BAND_STEP) * TW'(k)) band = 8'(k + 1);
    if (p_u[POS_W-1] || p_ext >= TW'(BAND_STEP) * TW'(NUM_BANDS)) band = 8'hFF;
  end

  always_ff @(posedge clk) begin
    if (reset || recal)                        led_out <= 8'h00;
    else if (vld_pipe[STAGES-1] & run_pipe[STAGES-1]) led_out <= band;
  end
endmodule

// File: tb/tb_esti_axis_integrator.sv
// Directed bench: calibration, integration, banding, saturation, overrun, recal and reset.

module tb_esti_axis_integrator;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, fd1, recal1, fd2, recal2;
  logic [47:0]  rx1;
  logic [31:0]  rx2;
  logic [95:0]  vel1;
  logic [191:0] pos1;
  logic [7:0]   led1, led2;
  logic         cd1, uv1, ov1, cd2, uv2, ov2;
  logic [2:0]   sat1;
  logic [15:0]  vel2;
  logic [31:0]  pos2;
  logic [1:0]   sat2;

  int checks = 0;
  int fails  = 0;

  esti_axis_integrator #(
    .NUM_AXES(3), .SAMPLE_W(16), .VEL_W(32), .POS_W(64), .CAL_LOG2(2),
    .BAND_STEP(64'd100), .NUM_BANDS(5), .LED_AXIS(0)
  ) dut1 (
    .clk(clk), .reset(reset), .frame_done(fd1), .rx_bytes(rx1), .recal(recal1),
    .vel(vel1), .pos(pos1), .led_out(led1), .cal_done(cd1), .upd_valid(uv1),
    .sat(sat1), .overrun(ov1)
  );

  esti_axis_integrator #(
    .NUM_AXES(2), .SAMPLE_W(16), .VEL_W(8), .POS_W(16), .CAL_LOG2(2),
    .BAND_STEP(64'd100), .NUM_BANDS(5), .LED_AXIS(0)
  ) dut2 (
    .clk(clk), .reset(reset), .frame_done(fd2), .rx_bytes(rx2), .recal(recal2),
    .vel(vel2), .pos(pos2), .led_out(led2), .cal_done(cd2), .upd_valid(uv2),
    .sat(sat2), .overrun(ov2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_v1(input string tag, input int ax, input int e);
    logic [31:0] ev;
    ev = e;
    check(tag, 64'(vel1[ax*32 +: 32]), 64'(ev));
  endtask

  task automatic chk_p1(input string tag, input int ax, input longint e);
    logic [63:0] ep;
    ep = e;
    check(tag, pos1[ax*64 +: 64], ep);
  endtask

  function automatic logic [47:0] mk1(input logic [15:0] a0, a1, a2);
    return {a2[7:0], a2[15:8], a1[7:0], a1[15:8], a0[7:0], a0[15:8]};
  endfunction

  function automatic logic [31:0] mk2(input logic [15:0] a0, a1);
    return {a1[7:0], a1[15:8], a0[7:0], a0[15:8]};
  endfunction

  // Drives one edge at cycle T and checks the pipeline at T+1..T+5.
  task automatic run_frame1(input logic [15:0] a0, a1, a2, input int ev, input longint ep,
                            input logic [7:0] el, input logic euv, input logic ecd1, ecd2);
    rx1 = mk1(a0, a1, a2);
    fd1 = 1'b1;
    tick();
    fd1 = 1'b0;
    check("cal_done_t1", 64'(cd1), 64'(ecd1));
    tick();
    chk_v1("vel0", 0, ev);
    check("cal_done_t2", 64'(cd1), 64'(ecd2));
    tick();
    chk_p1("pos0", 0, ep);
    tick();
    check("upd_valid_t4", 64'(uv1), 64'(euv));
    check("led_out", 64'(led1), 64'(el));
    tick();
    check("upd_valid_t5", 64'(uv1), 64'(1'b0));
  endtask

  task automatic run_frame2(input logic [15:0] a0, a1);
    rx2 = mk2(a0, a1);
    fd2 = 1'b1;
    tick();
    fd2 = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    reset = 1'b1; fd1 = 1'b0; recal1 = 1'b0; fd2 = 1'b0; recal2 = 1'b0;
    rx1 = '0; rx2 = '0;
    tick(); tick();
    check("rst_vel",  64'(vel1[63:0]), 64'd0);
    check("rst_pos",  pos1[63:0], 64'd0);
    check("rst_led",  64'(led1), 64'h00);
    check("rst_cd",   64'(cd1), 64'd0);
    check("rst_uv",   64'(uv1), 64'd0);
    check("rst_sat",  64'(sat1), 64'd0);
    check("rst_ov",   64'(ov1), 64'd0);
    reset = 1'b0;
    tick();

    // Calibration: axis0 bias 0x10, axis1 bias -4, axis2 bias 3
    run_frame1(16'h0010, 16'hFFFC, 16'h0003, 0, 0, 8'h00, 1'b0, 1'b0, 1'b0);
    run_frame1(16'h0012, 16'hFFFC, 16'h0003, 0, 0, 8'h00, 1'b0, 1'b0, 1'b0);
    run_frame1(16'h000E, 16'hFFFC, 16'h0003, 0, 0, 8'h00, 1'b0, 1'b0, 1'b0);
    run_frame1(16'h0010, 16'hFFFC, 16'h0003, 0, 0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Integration
    run_frame1(16'h0014, 16'h0000, 16'h0003, 4, 4, 8'h01, 1'b1, 1'b1, 1'b1);
    chk_v1("vel1_axis1", 1, 4);
    chk_v1("vel1_axis2", 2, 0);
    chk_p1("pos1_axis1", 1, 4);
    run_frame1(16'h0014, 16'h0000, 16'h0003, 8, 12, 8'h01, 1'b1, 1'b1, 1'b1);
    run_frame1(16'h0014, 16'h0000, 16'h0003, 12, 24, 8'h01, 1'b1, 1'b1, 1'b1);

    // Banding at 99, 100, 499, 500, -1, 0
    run_frame1(16'h004F, 16'h0000, 16'h0003, 75, 99, 8'h01, 1'b1, 1'b1, 1'b1);
    run_frame1(16'hFFC6, 16'h0000, 16'h0003, 1, 100, 8'h02, 1'b1, 1'b1, 1'b1);
    run_frame1(16'h019E, 16'h0000, 16'h0003, 399, 499, 8'h05, 1'b1, 1'b1, 1'b1);
    run_frame1(16'hFE82, 16'h0000, 16'h0003, 1, 500, 8'hFF, 1'b1, 1'b1, 1'b1);
    run_frame1(16'hFE1A, 16'h0000, 16'h0003, -501, -1, 8'hFF, 1'b1, 1'b1, 1'b1);
    run_frame1(16'h0206, 16'h0000, 16'h0003, 1, 0, 8'h01, 1'b1, 1'b1, 1'b1);
    check("sat_none", 64'(sat1), 64'd0);

    // Overrun: second edge two cycles after the first is dropped
    rx1 = mk1(16'h0014, 16'h0000, 16'h0003);
    fd1 = 1'b1; tick();
    fd1 = 1'b0; tick();
    fd1 = 1'b1; tick();
    fd1 = 1'b0; tick();
    check("ovr_flag", 64'(ov1), 64'd1);
    check("ovr_uv", 64'(uv1), 64'd1);
    tick();
    chk_v1("ovr_vel0", 0, 5);
    chk_p1("ovr_pos0", 0, 5);
    repeat (4) tick();
    chk_v1("ovr_vel0_late", 0, 5);
    check("ovr_uv_late", 64'(uv1), 64'd0);

    // recal coincident with an edge
    fd1 = 1'b1; recal1 = 1'b1; tick();
    fd1 = 1'b0; recal1 = 1'b0;
    check("rc_cd", 64'(cd1), 64'd0);
    check("rc_ov", 64'(ov1), 64'd0);
    chk_v1("rc_vel0", 0, 0);
    chk_p1("rc_pos0", 0, 0);
    check("rc_led", 64'(led1), 64'h00);
    repeat (4) begin
      tick();
      check("rc_uv", 64'(uv1), 64'd0);
    end
    run_frame1(16'h0010, 16'hFFFC, 16'h0003, 0, 0, 8'h00, 1'b0, 1'b0, 1'b0);
    run_frame1(16'h0012, 16'hFFFC, 16'h0003, 0, 0, 8'h00, 1'b0, 1'b0, 1'b0);
    run_frame1(16'h000E, 16'hFFFC, 16'h0003, 0, 0, 8'h00, 1'b0, 1'b0, 1'b0);
    run_frame1(16'h0010, 16'hFFFC, 16'h0003, 0, 0, 8'h00, 1'b0, 1'b0, 1'b1);
    run_frame1(16'h0014, 16'h0000, 16'h0003, 4, 4, 8'h01, 1'b1, 1'b1, 1'b1);

    // Reset in the middle of a frame
    rx1 = mk1(16'h0014, 16'h0000, 16'h0003);
    fd1 = 1'b1; tick();
    fd1 = 1'b0; tick();
    reset = 1'b1; tick();
    reset = 1'b0;
    chk_v1("mr_vel0", 0, 0);
    chk_p1("mr_pos0", 0, 0);
    check("mr_led", 64'(led1), 64'h00);
    check("mr_cd", 64'(cd1), 64'd0);
    check("mr_uv", 64'(uv1), 64'd0);
    check("mr_ov", 64'(ov1), 64'd0);
    tick();
    check("mr_uv2", 64'(uv1), 64'd0);
    run_frame1(16'h0014, 16'h0000, 16'h0003, 0, 0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Saturation on the narrow-velocity instance
    repeat (4) run_frame2(16'h0000, 16'h0000);
    check("s_cd", 64'(cd2), 64'd1);
    run_frame2(16'h007F, 16'h0001);
    check("s_vel0_a", 64'(vel2[7:0]), 64'h7F);
    check("s_pos0_a", 64'(pos2[15:0]), 64'd127);
    check("s_sat_a", 64'(sat2), 64'b00);
    run_frame2(16'h007F, 16'h0001);
    check("s_vel0_b", 64'(vel2[7:0]), 64'h7F);
    check("s_vel1_b", 64'(vel2[15:8]), 64'h02);
    check("s_pos0_b", 64'(pos2[15:0]), 64'd254);
    check("s_sat_b", 64'(sat2), 64'b01);
    recal2 = 1'b1; tick();
    recal2 = 1'b0;
    check("s_sat_clr", 64'(sat2), 64'b00);
    check("s_cd_clr", 64'(cd2), 64'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
